// File: rtl/ctu_clsp_domgif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctu_clsp_domgif_pkg
// Brief    : Shared definitions for the CTU CLSP domain global interface.
// Revision : 1.0 - initial release
// ============================================================================
package ctu_clsp_domgif_pkg;

    localparam int DEF_CNT_W    = 10;
    localparam int DEF_NUM_CKEN = 6;

    typedef enum logic {
        CLOSED = 1'b0,
        OPEN   = 1'b1
    } win_state_t;

    // Which input wins when release and assert coincide in one cycle
    typedef enum logic {
        REL_FIRST    = 1'b0,
        ASSERT_FIRST = 1'b1
    } prio_mode_t;

endpackage
`default_nettype wire

// File: rtl/ctu_clsp_syncwin.sv
`default_nettype none
// ============================================================================
// Module   : ctu_clsp_syncwin
// Brief    : Sync-edge window FSM, latency release compare and active-low
//            output flop for one global control (reset or debug-init).
// Revision : 1.0 - initial release
// ============================================================================
module ctu_clsp_syncwin
    import ctu_clsp_domgif_pkg::*;
#(
    parameter int         CNT_W = DEF_CNT_W,
    parameter prio_mode_t PRIO  = REL_FIRST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_clk,
    input  logic             sync_zero,
    input  logic             sync_req,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] latency,
    input  logic             assert_req,
    output logic             out_l
);

    win_state_t state;
    win_state_t state_nxt;
    logic       rel;
    logic       out_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLOSED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLOSED: begin
                if (sync_req && sync_zero) begin
                    state_nxt = OPEN;
                end
            end
            OPEN: begin
                // A fresh request on the closing edge re-arms the window
                if (sync_zero && !sync_req) begin
                    state_nxt = CLOSED;
                end
            end
            default: state_nxt = CLOSED;
        endcase
        if (!start_clk) begin
            state_nxt = CLOSED;
        end
    end

    assign rel = (state == OPEN) && (cnt == latency);

    generate
        if (PRIO == REL_FIRST) begin : g_rel_first
            assign out_nxt = start_clk & (rel ? 1'b1 : (assert_req ? 1'b0 : out_l));
        end else begin : g_assert_first
            assign out_nxt = start_clk & (assert_req ? 1'b0 : (rel ? 1'b1 : out_l));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_l <= 1'b0;
        end else begin
            out_l <= out_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ctu_clsp_domgif.sv
`default_nettype none
// ============================================================================
// Module   : ctu_clsp_domgif
// Brief    : Parametrised CTU clock-domain global interface: sync-edge
//            counter, global reset / debug-init release and clock enables.
//            Define CTU_CKEN_STAGE_EN for staged clock-enable turn-on.
// Revision : 1.0 - initial release
// ============================================================================
module ctu_clsp_domgif
    import ctu_clsp_domgif_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int NUM_CKEN = DEF_NUM_CKEN
) (
    input  logic                gclk,
    input  logic                io_pwron_rst_l,
    input  logic                start_clk_early_l,
    input  logic                start_clk,
    input  logic                testmode_l,
    input  logic                jtag_force_cken,
    input  logic [CNT_W-1:0]    div_mult,
    input  logic [CNT_W-1:0]    global_latency,
    input  logic                grst_edge,
    input  logic                dbginit_edge,
    input  logic                a_grst,
    input  logic                a_dbginit,
    input  logic [NUM_CKEN-1:0] cken_req,
    output logic                grst_out_l,
    output logic                dbginit_out_l,
    output logic                arst_l,
    output logic                adbginit_l,
    output logic [NUM_CKEN-1:0] cken,
    output logic                sync_zero
);

    logic [CNT_W-1:0]    cnt;
    logic                ld;
    logic                force_cken;
    logic [NUM_CKEN-1:0] cken_nxt;

    assign arst_l     = io_pwron_rst_l;
    assign adbginit_l = io_pwron_rst_l;

    // Counter runs div_mult..1; reload on the cycle it reaches 1 (or 0)
    assign sync_zero = (cnt[CNT_W-1:1] == '0);

    always_ff @(posedge gclk or negedge io_pwron_rst_l) begin
        if (!io_pwron_rst_l) begin
            ld  <= 1'b1;
            cnt <= '0;
        end else begin
            ld <= ~start_clk_early_l;
            if (!start_clk_early_l) begin
                cnt <= '0;
            end else if (ld || sync_zero) begin
                cnt <= div_mult;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    ctu_clsp_syncwin #(
        .CNT_W (CNT_W),
        .PRIO  (REL_FIRST)
    ) u_grst_win (
        .clk        (gclk),
        .rst_n      (io_pwron_rst_l),
        .start_clk  (start_clk),
        .sync_zero  (sync_zero),
        .sync_req   (grst_edge),
        .cnt        (cnt),
        .latency    (global_latency),
        .assert_req (a_grst),
        .out_l      (grst_out_l)
    );

    ctu_clsp_syncwin #(
        .CNT_W (CNT_W),
        .PRIO  (ASSERT_FIRST)
    ) u_dbginit_win (
        .clk        (gclk),
        .rst_n      (io_pwron_rst_l),
        .start_clk  (start_clk),
        .sync_zero  (sync_zero),
        .sync_req   (dbginit_edge),
        .cnt        (cnt),
        .latency    (global_latency),
        .assert_req (a_dbginit | a_grst),
        .out_l      (dbginit_out_l)
    );

    assign force_cken = jtag_force_cken | ~testmode_l;

`ifdef CTU_CKEN_STAGE_EN
    localparam logic [NUM_CKEN-1:0] STAGE_LSB = NUM_CKEN'(1);

    logic [NUM_CKEN-1:0] stage_mask;

    // One more channel is admitted on each sync edge after start_clk
    always_ff @(posedge gclk or negedge io_pwron_rst_l) begin
        if (!io_pwron_rst_l) begin
            stage_mask <= '0;
        end else if (!start_clk) begin
            stage_mask <= '0;
        end else if (sync_zero && !ld) begin
            stage_mask <= (stage_mask << 1) | STAGE_LSB;
        end
    end

    assign cken_nxt = force_cken ? {NUM_CKEN{1'b1}} : (cken_req & stage_mask);
`else
    assign cken_nxt = force_cken ? {NUM_CKEN{1'b1}} : (cken_req & {NUM_CKEN{start_clk}});
`endif

    always_ff @(posedge gclk or negedge io_pwron_rst_l) begin
        if (!io_pwron_rst_l) begin
            cken <= '0;
        end else begin
            cken <= cken_nxt;
        end
    end

endmodule
`default_nettype wire
